// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared types and constants for the Ethernet receive path:
//                MAC address type, header record, CRC-32 constants, header
//                and FCS lengths, and a saturating length-increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package eth_pkg;

  typedef logic [47:0] mac_t;

  // Ethernet header exactly as it appears on the wire (big-endian fields).
  typedef struct packed {
    mac_t        dst;
    mac_t        src;
    logic [15:0] etype;
  } eth_hdr_t;

  localparam mac_t        ETH_BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  localparam int ETH_HDR_LEN = 14;
  localparam int ETH_FCS_LEN = 4;

  // Frame byte counter width and its saturation value.
  localparam int          LEN_W   = 11;
  localparam logic [10:0] LEN_SAT = 11'd2047;

  // Length after one more byte, sticking at LEN_SAT instead of wrapping.
  function automatic logic [10:0] len_inc(input logic [10:0] n);
    return (n == LEN_SAT) ? n : n + 11'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_crc32.sv
`default_nettype none
// ============================================================================
//  Module      : eth_crc32
//  Description : Byte-wide next-state function of the Ethernet CRC-32
//                (reflected polynomial EDB88320, LSB of the byte first).
//                Purely combinational; the CRC register lives in the caller.
//  Ports       : crc_in  [31:0] current CRC register value
//                data    [7:0]  byte being absorbed
//                crc_out [31:0] CRC after absorbing data
//  Revision    : 1.0  initial release
// ============================================================================
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] w_c;

  // With the reflected form the whole byte can be XORed into the low bits
  // up front; each of the 8 shifts then consumes one data bit, LSB first.
  always_comb begin
    w_c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY_REFL) : (w_c >> 1);
    end
    crc_out = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/eth_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_frame
//  Description : Ethernet receive framer. Takes the byte stream from the RMII
//                receiver, captures the 14-byte header, filters on the
//                destination MAC, checks the CRC-32 FCS and forwards only the
//                payload (header and FCS stripped), followed by one status
//                beat per frame.
//  Ports       : clk, resetn (async, active-low)
//                rx_data_vld/rx_data_last/rx_data  input byte stream
//                out_vld/out_last/out_data         payload stream
//                hdr_vld + hdr_dst/hdr_src/hdr_type header fields
//                stat_vld + stat_crc_ok/runt/long/len per-frame status
//                drop                               address-filter discard
//  Revision    : 1.0  initial release
// ============================================================================
module eth_rx_frame
  import eth_pkg::*;
#(
  parameter mac_t MAC_ADDR  = 48'h0010A47BEA80,
  parameter bit   PROMISC   = 1'b0,
  parameter int   MIN_FRAME = 64,
  parameter int   MAX_FRAME = 1518
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_data_vld,
  input  logic        rx_data_last,
  input  logic [7:0]  rx_data,
  output logic        out_vld,
  output logic        out_last,
  output logic [7:0]  out_data,
  output logic        hdr_vld,
  output logic [47:0] hdr_dst,
  output logic [47:0] hdr_src,
  output logic [15:0] hdr_type,
  output logic        stat_vld,
  output logic        stat_crc_ok,
  output logic        stat_runt,
  output logic        stat_long,
  output logic [10:0] stat_len,
  output logic        drop
);

  // --------------------------------------------------------------------------
  // State encoding and byte-index landmarks
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DROP    = 2'd3;

  localparam logic [10:0] MIN_LEN      = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN      = 11'(MAX_FRAME);
  localparam logic [10:0] IDX_DST_LAST = 11'd5;
  localparam logic [10:0] IDX_HDR_LAST = 11'(ETH_HDR_LEN - 1);
  // First input index whose 4-deep delay output is a payload byte.
  localparam logic [10:0] IDX_FIRST_OUT = 11'(ETH_HDR_LEN + ETH_FCS_LEN);
  // Shortest frame for which an FCS check is meaningful.
  localparam logic [10:0] MIN_CRC_LEN  = 11'(ETH_FCS_LEN + 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]   r_state;
  logic [10:0]  r_cnt;       // index of the next byte; 0 between frames
  logic [31:0]  r_crc;
  logic [103:0] r_hdr_sr;    // last 13 header bytes, oldest in the MSBs
  logic [31:0]  r_dly;       // 4-byte delay line, oldest byte in [31:24]

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [31:0] w_crc_next;
  logic [10:0] w_len;
  logic        w_in_hdr;
  mac_t        w_dst_now;
  logic        w_dst_pass;
  logic        w_filt_fail;
  eth_hdr_t    w_hdr;

  eth_crc32 u_crc (
    .crc_in  (r_crc),
    .data    (rx_data),
    .crc_out (w_crc_next)
  );

  // Length of the frame including the current byte.
  assign w_len    = len_inc(r_cnt);
  assign w_in_hdr = (r_state == ST_IDLE) || (r_state == ST_HDR);

  // On byte 5 the destination is the five shifted-in bytes plus this one.
  assign w_dst_now  = {r_hdr_sr[39:0], rx_data};
  assign w_dst_pass = PROMISC || (w_dst_now == MAC_ADDR) || (w_dst_now == ETH_BCAST);
  assign w_filt_fail = w_in_hdr && (r_cnt == IDX_DST_LAST) && !w_dst_pass;

  // On byte 13 the complete header is the 13 stored bytes plus this one.
  assign w_hdr = {r_hdr_sr, rx_data};

  // --------------------------------------------------------------------------
  // Frame tracking, CRC and header shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_crc    <= CRC_INIT;
      r_hdr_sr <= '0;
      r_dly    <= '0;
    end else if (rx_data_vld) begin
      r_dly <= {r_dly[23:0], rx_data};

      // Counter and CRC rearm on the last byte so the next frame can start
      // on the very next cycle without passing through an idle beat.
      if (rx_data_last) begin
        r_cnt <= '0;
        r_crc <= CRC_INIT;
      end else begin
        r_cnt <= w_len;
        r_crc <= w_crc_next;
      end

      case (r_state)
        ST_IDLE, ST_HDR: begin
          r_hdr_sr <= {r_hdr_sr[95:0], rx_data};
          if (rx_data_last) begin
            r_state <= ST_IDLE;
          end else if (w_filt_fail) begin
            r_state <= ST_DROP;
          end else if (r_cnt == IDX_HDR_LAST) begin
            r_state <= ST_PAYLOAD;
          end else begin
            r_state <= ST_HDR;
          end
        end
        ST_PAYLOAD, ST_DROP: begin
          if (rx_data_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output registers: pulses default low each cycle, fields hold their value
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_vld     <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      hdr_vld     <= 1'b0;
      hdr_dst     <= '0;
      hdr_src     <= '0;
      hdr_type    <= '0;
      stat_vld    <= 1'b0;
      stat_crc_ok <= 1'b0;
      stat_runt   <= 1'b0;
      stat_long   <= 1'b0;
      stat_len    <= '0;
      drop        <= 1'b0;
    end else begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      hdr_vld  <= 1'b0;
      stat_vld <= 1'b0;
      drop     <= 1'b0;

      if (rx_data_vld) begin
        // Header complete (a frame ending exactly here still reports it).
        if ((r_state == ST_HDR) && (r_cnt == IDX_HDR_LAST)) begin
          hdr_vld  <= 1'b1;
          hdr_dst  <= w_hdr.dst;
          hdr_src  <= w_hdr.src;
          hdr_type <= w_hdr.etype;
        end

        // The byte leaving the delay line is payload once four bytes past
        // the header have been seen; the last four are the FCS and never leave.
        if ((r_state == ST_PAYLOAD) && (r_cnt >= IDX_FIRST_OUT)) begin
          out_vld  <= 1'b1;
          out_data <= r_dly[31:24];
          out_last <= rx_data_last;
        end

        if (rx_data_last) begin
          if ((r_state == ST_DROP) || w_filt_fail) begin
            drop <= 1'b1;
          end else begin
            stat_vld    <= 1'b1;
            stat_len    <= w_len;
            stat_runt   <= (w_len < MIN_LEN);
            stat_long   <= (w_len > MAX_LEN);
            stat_crc_ok <= (w_crc_next == CRC_RESIDUE) && (w_len >= MIN_CRC_LEN);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_frame
//  Description : Scoreboard bench for eth_rx_frame. Frames are built by the
//                bench, a reference model derives the expected header,
//                payload, status and drop responses from the frame bytes and
//                queues them; a monitor pops and compares on every DUT output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eth_rx_frame;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] data; logic last; } pay_t;
  typedef struct { logic [47:0] dst; logic [47:0] src; logic [15:0] etype; } hdr_t;
  typedef struct { logic crc_ok; logic runt; logic lng; logic [10:0] len; logic has_pay; } stat_t;

  localparam logic [47:0] STATION = 48'h0010A47BEA80;
  localparam logic [47:0] BCAST   = 48'hFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_data_vld = 1'b0;
  logic        rx_data_last = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        out_vld, out_last, hdr_vld, stat_vld, stat_crc_ok, stat_runt, stat_long, drop;
  logic [7:0]  out_data;
  logic [47:0] hdr_dst, hdr_src;
  logic [15:0] hdr_type;
  logic [10:0] stat_len;

  eth_rx_frame dut (
    .clk          (clk),
    .resetn       (resetn),
    .rx_data_vld  (rx_data_vld),
    .rx_data_last (rx_data_last),
    .rx_data      (rx_data),
    .out_vld      (out_vld),
    .out_last     (out_last),
    .out_data     (out_data),
    .hdr_vld      (hdr_vld),
    .hdr_dst      (hdr_dst),
    .hdr_src      (hdr_src),
    .hdr_type     (hdr_type),
    .stat_vld     (stat_vld),
    .stat_crc_ok  (stat_crc_ok),
    .stat_runt    (stat_runt),
    .stat_long    (stat_long),
    .stat_len     (stat_len),
    .drop         (drop)
  );

  always #5 clk = ~clk;

  pay_t  exp_pay[$];
  hdr_t  exp_hdr[$];
  stat_t exp_stat[$];
  int    exp_drop = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Bit-serial CRC over the first n bytes, straight from the LSB-first rule.
  function automatic logic [31:0] ref_crc(input bq_t b, input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[k][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  function automatic bq_t add_fcs(input bq_t f, input bit corrupt);
    bq_t         r;
    logic [31:0] c;
    r = f;
    c = ~ref_crc(f, f.size());
    r.push_back(c[7:0]);
    r.push_back(c[15:8]);
    r.push_back(c[23:16]);
    r.push_back(corrupt ? (c[31:24] ^ 8'h01) : c[31:24]);
    return r;
  endfunction

  task automatic expect_frame(input bq_t f);
    int          n;
    logic [47:0] dst;
    logic [31:0] fcs;
    stat_t       s;
    n = f.size();
    if (n >= 6) begin
      dst = {f[0], f[1], f[2], f[3], f[4], f[5]};
      if (dst != STATION && dst != BCAST) begin
        exp_drop++;
        return;
      end
    end
    if (n >= 14)
      exp_hdr.push_back('{dst: {f[0], f[1], f[2], f[3], f[4], f[5]},
                          src: {f[6], f[7], f[8], f[9], f[10], f[11]},
                          etype: {f[12], f[13]}});
    for (int k = 14; k <= n - 5; k++)
      exp_pay.push_back('{data: f[k], last: (k == n - 5)});
    s.len     = (n > 2047) ? 11'd2047 : 11'(n);
    s.runt    = (n < 64);
    s.lng     = (n > 1518);
    s.has_pay = (n > 18);
    if (n >= 5) begin
      fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
      s.crc_ok = (fcs == ~ref_crc(f, n - 4));
    end else begin
      s.crc_ok = 1'b0;
    end
    exp_stat.push_back(s);
  endtask

  // ---------------- frame builders ----------------
  function automatic bq_t t1_body(input logic [47:0] dst);
    bq_t f;
    for (int k = 0; k < 6; k++) f.push_back(dst[47-8*k -: 8]);
    f.push_back(8'h00); f.push_back(8'h12); f.push_back(8'h34);
    f.push_back(8'h56); f.push_back(8'h78); f.push_back(8'h90);
    f.push_back(8'h08); f.push_back(8'h00);
    f.push_back(8'h45); f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h2E);
    for (int k = 4; k < 46; k++) f.push_back((k >= 28) ? 8'(k - 28) : 8'h00);
    return f;
  endfunction

  function automatic bq_t rand_frame();
    bq_t         f;
    int          cat, n, m, dsel;
    bit          good;
    logic [47:0] dst;
    cat  = $urandom_range(0, 19);
    n    = (cat < 4) ? $urandom_range(1, 13) :
           (cat < 10) ? $urandom_range(14, 30) :
           (cat < 19) ? $urandom_range(60, 120) : $urandom_range(1500, 1530);
    dsel = $urandom_range(0, 3);
    dst  = (dsel == 0) ? BCAST : (dsel == 3) ? 48'({$urandom(), $urandom()}) : STATION;
    good = (n >= 5) && ($urandom_range(0, 3) != 0);
    m    = good ? n - 4 : n;
    for (int k = 0; k < m; k++) f.push_back((k < 6) ? dst[47-8*k -: 8] : 8'($urandom()));
    if (good) f = add_fcs(f, 1'b0);
    return f;
  endfunction

  // ---------------- driver ----------------
  // gap < 0 selects a random 0..3 idle cycles after each byte.
  task automatic send(input bq_t f, input int gap);
    int g;
    for (int k = 0; k < f.size(); k++) begin
      rx_data_vld  = 1'b1;
      rx_data      = f[k];
      rx_data_last = (k == f.size() - 1);
      @(posedge clk); #1;
      rx_data_vld  = 1'b0;
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      for (int i = 0; i < g; i++) begin
        rx_data      = 8'($urandom());
        rx_data_last = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      rx_data_last = 1'b0;
    end
  endtask

  task automatic issue(input bq_t f, input int gap);
    expect_frame(f);
    send(f, gap);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 128'({out_vld, out_last, out_data, hdr_vld, stat_vld, stat_crc_ok,
                                stat_runt, stat_long, stat_len, drop}), 128'(0));
    check({tag, "_hdr_dst"}, 128'(hdr_dst), 128'(0));
    check({tag, "_hdr_src_type"}, 128'({hdr_src, hdr_type}), 128'(0));
  endtask

  // ---------------- monitor ----------------
  pay_t  m_pay;
  hdr_t  m_hdr;
  stat_t m_stat;

  always @(negedge clk) begin
    if (resetn) begin
      if (out_vld) begin
        if (exp_pay.size() == 0) begin
          n_checks++;
          $display("FAIL payload_unexpected: got %02h expected none", out_data);
        end else begin
          m_pay = exp_pay.pop_front();
          check("payload", 128'({out_last, out_data}), 128'({m_pay.last, m_pay.data}));
        end
      end
      if (hdr_vld) begin
        if (exp_hdr.size() == 0) begin
          n_checks++;
          $display("FAIL hdr_unexpected: got %0h expected none", hdr_dst);
        end else begin
          m_hdr = exp_hdr.pop_front();
          check("hdr", 128'({hdr_dst, hdr_src, hdr_type}), 128'({m_hdr.dst, m_hdr.src, m_hdr.etype}));
        end
      end
      if (stat_vld) begin
        if (exp_stat.size() == 0) begin
          n_checks++;
          $display("FAIL stat_unexpected: got len %0d expected none", stat_len);
        end else begin
          m_stat = exp_stat.pop_front();
          check("stat", 128'({stat_crc_ok, stat_runt, stat_long, stat_len, out_vld & out_last}),
                128'({m_stat.crc_ok, m_stat.runt, m_stat.lng, m_stat.len, m_stat.has_pay}));
        end
      end
      if (drop) begin
        n_checks++;
        if (exp_drop > 0) begin
          exp_drop--;
          n_pass++;
        end else begin
          $display("FAIL drop_unexpected: got 1 expected 0");
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bq_t f, t1;

    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    t1 = add_fcs(t1_body(STATION), 1'b0);

    // Reference frame, bad FCS, filtered destination, 5-byte runt.
    issue(t1, 3);
    issue(add_fcs(t1_body(STATION), 1'b1), 3);
    f = t1_body(STATION);
    f[0] = 8'h02;
    issue(add_fcs(f, 1'b0), 3);
    f = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    issue(f, 3);

    // Broadcast at 1 byte / 4 clk, then two frames back-to-back at 1 byte/clk.
    issue(add_fcs(t1_body(BCAST), 1'b0), 3);
    issue(t1, 0);
    issue(t1, 0);
    repeat (5) @(posedge clk); #1;

    // Asynchronous reset in the middle of the payload.
    expect_frame(t1);
    for (int k = 0; k < 40; k++) begin
      rx_data_vld = 1'b1;
      rx_data     = t1[k];
      @(posedge clk); #1;
    end
    rx_data_vld = 1'b0;
    #2;
    check("pre_reset_out_vld", 128'(out_vld), 128'(1));
    resetn = 1'b0;
    #1;
    check_zero("async_reset");
    exp_pay.delete();
    exp_hdr.delete();
    exp_stat.delete();
    exp_drop = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    issue(t1, 0);

    // Randomized frames, mixed lengths, addresses, FCS and spacing.
    for (int i = 0; i < 30; i++) begin
      f = rand_frame();
      issue(f, (f.size() > 200) ? 0 : -1);
    end

    // Over-length frame that saturates the length counter.
    f = t1_body(STATION);
    while (f.size() < 2096) f.push_back(8'($urandom()));
    issue(add_fcs(f, 1'b0), 0);

    repeat (30) @(posedge clk);
    #1;
    check("pay_queue_drained", 128'(exp_pay.size()), 128'(0));
    check("hdr_queue_drained", 128'(exp_hdr.size()), 128'(0));
    check("stat_queue_drained", 128'(exp_stat.size()), 128'(0));
    check("drop_count_drained", 128'(exp_drop), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_rx_frame.md
Name: eth_rx_frame

Overview:
- Consumes the byte stream (rx_data_vld / rx_data_last / rx_data) from the RMII receive block, one byte per valid, no back-pressure.
- Parses the Ethernet header, filters on destination MAC, checks the CRC-32 FCS, and strips header and FCS.
- Emits the payload stream plus one per-frame status beat. Sits between the RMII RX stage and the IP/UDP layer.

Parameters:
- MAC_ADDR, 48'h0010A47BEA80, station address accepted as destination
- PROMISC, 0, 1 = accept any destination
- MIN_FRAME, 64, minimum legal length in bytes, FCS included
- MAX_FRAME, 1518, maximum legal length in bytes, FCS included

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- rx_data_vld  in  1  input byte valid
- rx_data_last  in  1  marks last byte of frame (FCS byte 3); qualified by rx_data_vld
- rx_data  in  8  input byte
- out_vld  out  1  payload byte valid
- out_last  out  1  last payload byte of frame
- out_data  out  8  payload byte
- hdr_vld  out  1  one-cycle pulse: header fields valid
- hdr_dst  out  48  destination MAC
- hdr_src  out  48  source MAC
- hdr_type  out  16  ethertype
- stat_vld  out  1  one-cycle pulse: frame status valid
- stat_crc_ok  out  1  FCS residue correct
- stat_runt  out  1  length < MIN_FRAME
- stat_long  out  1  length > MAX_FRAME
- stat_len  out  11  byte count incl. FCS, saturating at 2047
- drop  out  1  one-cycle pulse: frame discarded by address filter

Behaviour:
- Reset: resetn low clears all outputs to 0 immediately, clears the counter and CRC (CRC to FFFFFFFF), and puts the FSM in IDLE. No byte is accepted while resetn is low.
- FSM states and transitions:
  - IDLE: any rx_data_vld starts a frame; that byte is index 0; go to HDR.
  - HDR: bytes 0-13 are captured (dst = 0-5, src = 6-11, type = 12-13, big-endian).
  - After byte 5: the filter passes if dst == MAC_ADDR, dst == FFFFFFFFFFFF, or PROMISC = 1. On a fail, go to DROP.
  - After byte 13: hdr_vld pulses on the next cycle, with the fields held stable until the next frame's hdr_vld; go to PAYLOAD.
  - PAYLOAD: bytes pass through a 4-byte delay line so the FCS is never forwarded. The byte pushed out by input index i >= 18 is emitted as out_data one cycle after that input beat.
  - DROP: consume bytes until rx_data_last; drop pulses the cycle after. No out_vld, hdr_vld or stat_vld for that frame.
- CRC: CRC-32, poly 04C11DB7 reflected (EDB88320), LSB-first, init FFFFFFFF. It runs over every byte including the FCS. The good residue is DEBB20E3 after the last byte.
- Frame end (rx_data_last with rx_data_vld, in any non-DROP state, cycle N):
  - Cycle N+1: stat_vld=1, together with the final out_vld/out_last payload beat if any payload exists; FSM returns to IDLE.
  - stat_len = bytes received including FCS.
  - stat_runt, stat_long and stat_crc_ok are judged over the whole frame; stat_crc_ok is forced 0 if the frame has fewer than 5 bytes.
  - A frame ending before byte 5 is never dropped. It reports status, normally runt.
  - A frame ending before byte 13 gives no hdr_vld.
  - A frame of 18 bytes or fewer emits no payload beats, only stat_vld.
- Input gaps: rx_data_vld low cycles are ignored and state is held. Typical spacing is 1 byte per 4 clk; back-to-back bytes every cycle must also work.
- rx_data_last with rx_data_vld low is ignored.
- A new frame may start the cycle after rx_data_last; stat of the previous frame and byte 0 of the next frame overlap without interaction.
- Counter saturates at 2047; stat_long is set.
- Reset released mid-frame: the remainder of the frame is treated as a new frame (it fails CRC or the filter); no recovery logic.

Decomposition:
- Package eth_pkg holds:
  - mac_t (48-bit) type
  - ETH_BCAST, ETH_TYPE_IPV4 = 16'h0800
  - CRC_POLY_REFL = 32'hEDB88320, CRC_INIT, CRC_RESIDUE = 32'hDEBB20E3
  - ETH_HDR_LEN = 14, ETH_FCS_LEN = 4
- Sub-module: eth_crc32, a byte-wide combinational next-CRC function, instantiated once. The CRC register itself lives in eth_rx_frame.

Test Plan:
- 60-byte frame 00 10 A4 7B EA 80 00 12 34 56 78 90 08 00 45 00 ... 10 11, followed by FCS E6 C5 3D B2 -> expected response:
  - hdr_dst=0010A47BEA80, hdr_src=001234567890, hdr_type=0800
  - 46 payload beats 45 00 00 2E ... 10 11, out_last on 11
  - stat_crc_ok=1, stat_len=64, runt=0, long=0
- Same frame with the last FCS byte changed to B3 -> identical payload; stat_crc_ok=0.
- Same frame with first byte 02, PROMISC=0 -> no out_vld, hdr_vld or stat_vld; drop=1 once, the cycle after last.
- 5-byte frame A1 B2 C3 D4 E5 -> no hdr_vld, no payload; stat_vld with stat_runt=1, stat_len=5, stat_crc_ok=0.
- Test 1 with dst FFFFFFFFFFFF (FCS recomputed by the bench) sent 1 byte per 4 clk, then 2 frames back-to-back at 1 byte/clk -> payload and status identical to test 1 for each.
- resetn pulsed low mid-payload -> all outputs 0 asynchronously; the following test-1 frame is processed exactly as in test 1.
